seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
- Owns the four digit/enable inputs of the Basys3 7-segment driver and decides what they show each 1 kHz tick.
- Arbitrates between two requesters:
  - the game's continuous score/timer value, with leading-zero blanking and blink;
  - a one-shot message requester (e.g. "FAIL", "Good") that pre-empts the game value for a fixed hold time via a valid/ready handshake.
- Sits between the game FSM and basys3_7seg_driver, in the same clock domain.

Parameters:
- BLINK_HALF_MS, 250, cycles per blink half-period (on time = off time); must be >= 1.
- MSG_HOLD_MS, 1000, cycles a captured message stays on the display; must be >= 1.

Ports:
- clk_1k_i  in  1  1 kHz system clock.
- rst_i  in  1  asynchronous, active-high reset.
- game_value_i  in  16  game digits; [15:12] = digit3 (leftmost) … [3:0] = digit0.
- game_blank_lz_i  in  1  1 = blank leading zeros of game value.
- game_blink_i  in  1  1 = blink the game value.
- msg_valid_i  in  1  message request.
- msg_value_i  in  16  message digits, same packing as game_value_i.
- msg_en_i  in  4  per-digit enables for the message; bit n = digit n.
- msg_ready_o  out  1  arbiter can accept a message.
- msg_active_o  out  1  a message is currently displayed.
- digit0_en_o..digit3_en_o  out  1 each  enables to driver.
- digit0_o..digit3_o  out  4 each  digit codes to driver.

Behaviour:
- Clock and reset: one clock, clk_1k_i. Reset rst_i is asynchronous and active-high.
- Reset values:
  - all digitN_en_o = 0, all digitN_o = 4'h0;
  - msg_ready_o = 0, msg_active_o = 0;
  - FSM = GAME, hold and blink counters = 0, blink phase = ON.
  - msg_ready_o rises on the first clock edge after reset release.
- FSM states: GAME, MSG_HOLD.
  - GAME: msg_ready_o = 1. If msg_valid_i = 1 at an edge: capture msg_value_i/msg_en_i, load hold_cnt = MSG_HOLD_MS-1, go to MSG_HOLD.
  - MSG_HOLD: msg_ready_o = 0, msg_active_o = 1. hold_cnt decrements each cycle. When hold_cnt == 0, return to GAME at that edge.
  - Result: the message is shown for exactly MSG_HOLD_MS cycles.
- Handshake:
  - Transfer occurs only when valid && ready at an edge.
  - msg_valid_i during MSG_HOLD is ignored; requester holds valid until it sees ready.
  - Valid on the exit cycle of MSG_HOLD is not accepted until the next cycle, when ready = 1.
- Outputs are registered, with one-cycle latency from input change to digit outputs:
  - Message displayed starting the cycle after capture.
  - Game value resumes the cycle after MSG_HOLD exits.
- Message display: digitN_o = captured nibble; digitN_en_o = captured msg_en_i[n]. Blink and blanking are not applied.
- Game display, leading-zero blanking (when game_blank_lz_i = 1):
  - digit3 is blanked if its nibble is 0;
  - digit2 is blanked if nibbles 3..2 are all 0;
  - digit1 is blanked if nibbles 3..1 are all 0;
  - digit0 is never blanked, so 16'h0000 shows a single "0".
  - When game_blank_lz_i = 0, all enables are 1.
- Blink:
  - When game_blink_i = 0: blink counter is cleared and phase = ON.
  - When game_blink_i = 1: the counter runs 0..BLINK_HALF_MS-1, and phase toggles on wrap. The first ON phase after blink asserts lasts BLINK_HALF_MS cycles.
  - OFF phase forces all game enables to 0; digit codes still track the game value.
  - The blink counter keeps running during MSG_HOLD, so phase stays continuous.
- Disabled digits: digitN_o still reflects the selected source value (don't-care for the driver, but defined for verification).
- Reset mid-hold: display blanks immediately (async), FSM returns to GAME, and the captured message is discarded.
- Counter widths are $clog2(param+1). No wrap-around beyond the defined ranges.

Decomposition:
- Package seg_display_pkg holds:
  - typedef enum logic [0:0] {GAME, MSG_HOLD} disp_state_e;
  - the packed typedef digits4_t (4 × logic [3:0]);
  - the function lz_enables(digits4_t) returning logic [3:0].
- Sub-module seg_blink_timer (ports: clk_1k_i, rst_i, en_i, phase_on_o, parameter HALF_MS) holds the blink counter and phase.
- The arbiter FSM, hold counter and output registers live in seg_display_arbiter.

Test Plan (bench uses BLINK_HALF_MS = 4, MSG_HOLD_MS = 6):
- Reset, then game_value_i = 16'h0042, blank_lz = 1 -> one cycle later: en = {0,0,1,1}, digit1 = 4, digit0 = 2; msg_ready_o = 1.
- game_value_i = 16'h0000, blank_lz = 1 -> only digit0_en_o = 1, digit0_o = 0. Then blank_lz = 0 -> all four enables = 1.
- blink = 1 with value 16'h1234 -> enables all 1 for 4 cycles, 0 for 4 cycles, repeating. Deassert blink mid-OFF -> enables back to 1 on the next cycle.
- msg_valid_i = 1, msg_value_i = 16'hFA1E, msg_en_i = 4'b1111 in GAME -> ready drops next cycle; message shown for exactly 6 cycles; msg_active_o high for those 6 cycles; game value returns afterwards.
- Second msg_valid_i held during MSG_HOLD -> not captured until ready = 1; then displayed for a full 6 cycles. A message during blink OFF phase is displayed fully lit.
- Assert rst_i asynchronously in the middle of MSG_HOLD -> all enables = 0 immediately; after release the FSM is in GAME with ready = 1 and the old message gone.

Source files
------------

// File: rtl/seg_display_arbiter_pkg.sv
// Shared types and helpers for the 7-segment display arbiter.
// Digit packing: digits4_t[3] is the leftmost digit ([15:12] of a 16-bit value),
// digits4_t[0] the rightmost ([3:0]).
package seg_display_pkg;

    // Arbiter states: game value on display, or a captured message being held.
    typedef enum logic [0:0] {
        GAME     = 1'b0,
        MSG_HOLD = 1'b1
    } disp_state_e;

    // Four BCD/hex digit codes, digit n in element [n].
    typedef logic [3:0][3:0] digits4_t;

    // Leading-zero blanking enables. A digit is lit once any digit at or to
    // its left is non-zero; the rightmost digit is always lit so that a zero
    // value still shows a single "0".
    function automatic logic [3:0] lz_enables(input digits4_t d);
        logic [3:0] en;
        en[3] = (d[3] != 4'h0);
        en[2] = en[3] | (d[2] != 4'h0);
        en[1] = en[2] | (d[1] != 4'h0);
        en[0] = 1'b1;
        return en;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Bundle of the game/message requester inputs and the driver-facing outputs
// of the display arbiter. The arbiter takes the slave view; whoever drives
// the requests and watches the display (game FSM glue, a bench) takes master.
interface seg_display_arbiter_if;

    // Game requester
    logic [15:0] game_value_i;
    logic        game_blank_lz_i;
    logic        game_blink_i;

    // Message requester (valid/ready)
    logic        msg_valid_i;
    logic [15:0] msg_value_i;
    logic [3:0]  msg_en_i;
    logic        msg_ready_o;
    logic        msg_active_o;

    // Towards basys3_7seg_driver
    logic        digit0_en_o;
    logic        digit1_en_o;
    logic        digit2_en_o;
    logic        digit3_en_o;
    logic [3:0]  digit0_o;
    logic [3:0]  digit1_o;
    logic [3:0]  digit2_o;
    logic [3:0]  digit3_o;

    modport slave (
        input  game_value_i, game_blank_lz_i, game_blink_i,
        input  msg_valid_i, msg_value_i, msg_en_i,
        output msg_ready_o, msg_active_o,
        output digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o,
        output digit0_o, digit1_o, digit2_o, digit3_o
    );

    modport master (
        output game_value_i, game_blank_lz_i, game_blink_i,
        output msg_valid_i, msg_value_i, msg_en_i,
        input  msg_ready_o, msg_active_o,
        input  digit0_en_o, digit1_en_o, digit2_en_o, digit3_en_o,
        input  digit0_o, digit1_o, digit2_o, digit3_o
    );

endinterface

// File: rtl/seg_display_arbiter_blink_timer.sv
// Blink phase generator. While enabled, a counter runs 0..HALF_MS-1 and the
// phase flips on each wrap, giving equal ON and OFF halves that start with a
// full ON half. While disabled the counter is parked at 0 with phase ON.
module seg_blink_timer #(
    parameter int HALF_MS = 250
) (
    input  logic clk_1k_i,
    input  logic rst_i,
    input  logic en_i,
    output logic phase_on_o
);

    localparam int            CW   = $clog2(HALF_MS + 1);
    localparam logic [CW-1:0] LAST = CW'(HALF_MS - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          phase_reg;
    logic          phase_next;

    // Next counter value and phase: clear when idle, wrap and toggle at LAST.
    always_comb begin
        cnt_next   = cnt_reg;
        phase_next = phase_reg;
        if (!en_i) begin
            cnt_next   = '0;
            phase_next = 1'b1;
        end else if (cnt_reg == LAST) begin
            cnt_next   = '0;
            phase_next = ~phase_reg;
        end else begin
            cnt_next   = cnt_reg + CW'(1);
        end
    end

    // Counter and phase registers; reset lands in the ON phase.
    always_ff @(posedge clk_1k_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b1;
        end else begin
            cnt_reg   <= cnt_next;
            phase_reg <= phase_next;
        end
    end

    assign phase_on_o = phase_reg;

endmodule

// File: rtl/seg_display_arbiter.sv
// Display arbiter in front of the Basys3 7-segment driver. Shows the game
// value (with optional leading-zero blanking and blink) unless a one-shot
// message has been accepted, in which case the message is held on the
// display for exactly MSG_HOLD_MS cycles. All outputs are registered and are
// computed from the next state, so any input change shows up one cycle later.
module seg_display_arbiter
    import seg_display_pkg::*;
#(
    parameter int BLINK_HALF_MS = 250,
    parameter int MSG_HOLD_MS   = 1000
) (
    input  logic                  clk_1k_i,
    input  logic                  rst_i,
    seg_display_arbiter_if.slave  bus
);

    localparam int            HW        = $clog2(MSG_HOLD_MS + 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(MSG_HOLD_MS - 1);

    disp_state_e   state_reg;
    disp_state_e   state_next;
    logic [HW-1:0] hold_cnt_reg;
    logic [HW-1:0] hold_cnt_next;
    digits4_t      msg_val_reg;
    digits4_t      msg_val_next;
    logic [3:0]    msg_en_reg;
    logic [3:0]    msg_en_next;

    logic          ready_reg;
    logic          ready_next;
    logic          active_reg;
    logic          active_next;
    digits4_t      digit_reg;
    digits4_t      digit_next;
    logic [3:0]    en_reg;
    logic [3:0]    en_next;

    digits4_t      game_digits;
    logic [3:0]    game_en;
    logic          show_msg;
    logic          phase_on;

    assign game_digits = bus.game_value_i;

    // Blink phase keeps running regardless of FSM state so that the game
    // value resumes in step with its blink cadence after a message.
    seg_blink_timer #(
        .HALF_MS (BLINK_HALF_MS)
    ) u_blink (
        .clk_1k_i   (clk_1k_i),
        .rst_i      (rst_i),
        .en_i       (bus.game_blink_i),
        .phase_on_o (phase_on)
    );

    // State, hold counter and captured message; reset discards any message.
    always_ff @(posedge clk_1k_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg    <= GAME;
            hold_cnt_reg <= '0;
            msg_val_reg  <= '0;
            msg_en_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            hold_cnt_reg <= hold_cnt_next;
            msg_val_reg  <= msg_val_next;
            msg_en_reg   <= msg_en_next;
        end
    end

    // Next state: accept a message only on valid && ready, then count the
    // hold down to zero and leave on the edge where the count is zero.
    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        msg_val_next  = msg_val_reg;
        msg_en_next   = msg_en_reg;
        case (state_reg)
            GAME: begin
                if (bus.msg_valid_i && ready_reg) begin
                    msg_val_next  = bus.msg_value_i;
                    msg_en_next   = bus.msg_en_i;
                    hold_cnt_next = HOLD_LOAD;
                    state_next    = MSG_HOLD;
                end
            end
            MSG_HOLD: begin
                if (hold_cnt_reg == '0) begin
                    state_next = GAME;
                end else begin
                    hold_cnt_next = hold_cnt_reg - HW'(1);
                end
            end
            default: begin
                state_next = GAME;
            end
        endcase
    end

    // Output decode from the next state: handshake flags, source select and
    // the game enables after blanking and blink gating. Blink gating uses the
    // live blink input so dropping blink relights the digits immediately.
    always_comb begin
        ready_next  = (state_next == GAME);
        active_next = (state_next == MSG_HOLD);
        show_msg    = active_next;
        game_en     = bus.game_blank_lz_i ? lz_enables(game_digits) : 4'b1111;
        if (bus.game_blink_i && !phase_on) begin
            game_en = 4'b0000;
        end
    end

    // Per-digit source mux; disabled digits still carry the selected code.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        assign digit_next[gi] = show_msg ? msg_val_next[gi] : game_digits[gi];
        assign en_next[gi]    = show_msg ? msg_en_next[gi]  : game_en[gi];
    end

    // Registered outputs; reset blanks the display and holds off requesters.
    always_ff @(posedge clk_1k_i or posedge rst_i) begin
        if (rst_i) begin
            ready_reg  <= 1'b0;
            active_reg <= 1'b0;
            digit_reg  <= '0;
            en_reg     <= '0;
        end else begin
            ready_reg  <= ready_next;
            active_reg <= active_next;
            digit_reg  <= digit_next;
            en_reg     <= en_next;
        end
    end

    assign bus.msg_ready_o  = ready_reg;
    assign bus.msg_active_o = active_reg;
    assign bus.digit0_o     = digit_reg[0];
    assign bus.digit1_o     = digit_reg[1];
    assign bus.digit2_o     = digit_reg[2];
    assign bus.digit3_o     = digit_reg[3];
    assign bus.digit0_en_o  = en_reg[0];
    assign bus.digit1_en_o  = en_reg[1];
    assign bus.digit2_en_o  = en_reg[2];
    assign bus.digit3_en_o  = en_reg[3];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with BLINK_HALF_MS = 4 and
// MSG_HOLD_MS = 6. Inputs change 1 time unit after a rising edge and outputs
// are checked at that same point, i.e. one full edge after the stimulus.
module tb_seg_display_arbiter;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    seg_display_arbiter_if bus ();

    seg_display_arbiter #(
        .BLINK_HALF_MS (4),
        .MSG_HOLD_MS   (6)
    ) dut (
        .clk_1k_i (clk),
        .rst_i    (rst),
        .bus      (bus)
    );

    logic [3:0]  obs_en;
    logic [15:0] obs_dig;
    assign obs_en  = {bus.digit3_en_o, bus.digit2_en_o, bus.digit1_en_o, bus.digit0_en_o};
    assign obs_dig = {bus.digit3_o, bus.digit2_o, bus.digit1_o, bus.digit0_o};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.game_value_i    = 16'h0000;
        bus.game_blank_lz_i = 1'b0;
        bus.game_blink_i    = 1'b0;
        bus.msg_valid_i     = 1'b0;
        bus.msg_value_i     = 16'h0000;
        bus.msg_en_i        = 4'b0000;
        #1;
        total++; if (obs_en !== 4'b0000) begin bad++; $display("FAIL reset_en got=%b want=0000", obs_en); end
        total++; if (obs_dig !== 16'h0000) begin bad++; $display("FAIL reset_dig got=%h want=0000", obs_dig); end
        total++; if (bus.msg_ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.msg_ready_o); end
        total++; if (bus.msg_active_o !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", bus.msg_active_o); end
        tick();
        tick();
        total++; if (bus.msg_ready_o !== 1'b0) begin bad++; $display("FAIL reset_held_ready got=%b want=0", bus.msg_ready_o); end
        rst = 1'b0;
        bus.game_value_i    = 16'h0042;
        bus.game_blank_lz_i = 1'b1;
        tick();
        total++; if (bus.msg_ready_o !== 1'b1) begin bad++; $display("FAIL first_ready got=%b want=1", bus.msg_ready_o); end
        total++; if (obs_en !== 4'b0011) begin bad++; $display("FAIL first_en got=%b want=0011", obs_en); end
        total++; if (obs_dig !== 16'h0042) begin bad++; $display("FAIL first_dig got=%h want=0042", obs_dig); end
        total++; if (bus.msg_active_o !== 1'b0) begin bad++; $display("FAIL first_active got=%b want=0", bus.msg_active_o); end
        $display("txn reset: en=%b dig=%h ready=%b", obs_en, obs_dig, bus.msg_ready_o);
    endtask

    task automatic test_blanking();
        logic [15:0] vals [5] = '{16'h0000, 16'h0005, 16'h0100, 16'h0030, 16'h1000};
        logic [3:0]  exps [5] = '{4'b0001, 4'b0001, 4'b0111, 4'b0011, 4'b1111};
        bus.game_blank_lz_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.game_value_i = vals[i];
            tick();
            total++; if (obs_en !== exps[i]) begin bad++; $display("FAIL lz_en[%0d] got=%b want=%b", i, obs_en, exps[i]); end
            total++; if (obs_dig !== vals[i]) begin bad++; $display("FAIL lz_dig[%0d] got=%h want=%h", i, obs_dig, vals[i]); end
            $display("txn blank_lz value=%h en=%b", vals[i], obs_en);
        end
        bus.game_value_i    = 16'h0000;
        bus.game_blank_lz_i = 1'b0;
        tick();
        total++; if (obs_en !== 4'b1111) begin bad++; $display("FAIL nolz_en got=%b want=1111", obs_en); end
        total++; if (obs_dig !== 16'h0000) begin bad++; $display("FAIL nolz_dig got=%h want=0000", obs_dig); end
        $display("txn no_blank value=0000 en=%b", obs_en);
    endtask

    task automatic test_blink();
        logic [3:0] want;
        bus.game_value_i    = 16'h1234;
        bus.game_blank_lz_i = 1'b1;
        bus.game_blink_i    = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            want = (((i / 4) % 2) == 0) ? 4'b1111 : 4'b0000;
            total++; if (obs_en !== want) begin bad++; $display("FAIL blink_en[%0d] got=%b want=%b", i, obs_en, want); end
            total++; if (obs_dig !== 16'h1234) begin bad++; $display("FAIL blink_dig[%0d] got=%h want=1234", i, obs_dig); end
            $display("txn blink cycle=%0d en=%b", i, obs_en);
        end
        bus.game_blink_i = 1'b0;
        tick();
        total++; if (obs_en !== 4'b1111) begin bad++; $display("FAIL blink_stop_en got=%b want=1111", obs_en); end
        tick();
        total++; if (obs_en !== 4'b1111) begin bad++; $display("FAIL blink_idle_en got=%b want=1111", obs_en); end
        $display("txn blink_off en=%b", obs_en);
    endtask

    task automatic test_message();
        total++; if (bus.msg_ready_o !== 1'b1) begin bad++; $display("FAIL msg_pre_ready got=%b want=1", bus.msg_ready_o); end
        bus.msg_valid_i = 1'b1;
        bus.msg_value_i = 16'hFA1E;
        bus.msg_en_i    = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 0) bus.msg_valid_i = 1'b0;
            if (i < 6) begin
                total++; if (obs_dig !== 16'hFA1E) begin bad++; $display("FAIL msg_dig[%0d] got=%h want=fa1e", i, obs_dig); end
                total++; if (bus.msg_active_o !== 1'b1) begin bad++; $display("FAIL msg_active[%0d] got=%b want=1", i, bus.msg_active_o); end
                total++; if (bus.msg_ready_o !== 1'b0) begin bad++; $display("FAIL msg_ready[%0d] got=%b want=0", i, bus.msg_ready_o); end
            end else begin
                total++; if (obs_dig !== 16'h1234) begin bad++; $display("FAIL msg_exit_dig got=%h want=1234", obs_dig); end
                total++; if (bus.msg_active_o !== 1'b0) begin bad++; $display("FAIL msg_exit_active got=%b want=0", bus.msg_active_o); end
                total++; if (bus.msg_ready_o !== 1'b1) begin bad++; $display("FAIL msg_exit_ready got=%b want=1", bus.msg_ready_o); end
            end
            total++; if (obs_en !== 4'b1111) begin bad++; $display("FAIL msg_en[%0d] got=%b want=1111", i, obs_en); end
            $display("txn message cycle=%0d dig=%h en=%b active=%b ready=%b", i, obs_dig, obs_en, bus.msg_active_o, bus.msg_ready_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] want_dig;
        logic [3:0]  want_en;
        logic        want_act;
        bus.game_value_i = 16'h1234;
        bus.game_blink_i = 1'b1;
        bus.msg_valid_i  = 1'b1;
        bus.msg_value_i  = 16'hFA1E;
        bus.msg_en_i     = 4'b1111;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (i < 6) begin
                want_dig = 16'hFA1E; want_en = 4'b1111; want_act = 1'b1;
            end else if (i == 6) begin
                want_dig = 16'h1234; want_en = 4'b0000; want_act = 1'b0;
            end else if (i < 13) begin
                want_dig = 16'h600D; want_en = 4'b1111; want_act = 1'b1;
            end else if (i < 16) begin
                want_dig = 16'h1234; want_en = 4'b0000; want_act = 1'b0;
            end else begin
                want_dig = 16'h1234; want_en = 4'b1111; want_act = 1'b0;
            end
            total++; if (obs_dig !== want_dig) begin bad++; $display("FAIL b2b_dig[%0d] got=%h want=%h", i, obs_dig, want_dig); end
            total++; if (obs_en !== want_en) begin bad++; $display("FAIL b2b_en[%0d] got=%b want=%b", i, obs_en, want_en); end
            total++; if (bus.msg_active_o !== want_act) begin bad++; $display("FAIL b2b_active[%0d] got=%b want=%b", i, bus.msg_active_o, want_act); end
            total++; if (bus.msg_ready_o !== !want_act) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=%b", i, bus.msg_ready_o, !want_act); end
            $display("txn back_to_back cycle=%0d dig=%h en=%b active=%b", i, obs_dig, obs_en, bus.msg_active_o);
            if (i == 0) bus.msg_value_i = 16'h600D;
            if (i == 7) bus.msg_valid_i = 1'b0;
        end
        bus.game_blink_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_hold();
        bus.msg_valid_i = 1'b1;
        bus.msg_value_i = 16'h600D;
        bus.msg_en_i    = 4'b0101;
        tick();
        bus.msg_valid_i = 1'b0;
        total++; if (obs_en !== 4'b0101) begin bad++; $display("FAIL hold_en got=%b want=0101", obs_en); end
        total++; if (obs_dig !== 16'h600D) begin bad++; $display("FAIL hold_dig got=%h want=600d", obs_dig); end
        tick();
        tick();
        #3;
        rst = 1'b1;
        #1;
        total++; if (obs_en !== 4'b0000) begin bad++; $display("FAIL async_en got=%b want=0000", obs_en); end
        total++; if (obs_dig !== 16'h0000) begin bad++; $display("FAIL async_dig got=%h want=0000", obs_dig); end
        total++; if (bus.msg_active_o !== 1'b0) begin bad++; $display("FAIL async_active got=%b want=0", bus.msg_active_o); end
        total++; if (bus.msg_ready_o !== 1'b0) begin bad++; $display("FAIL async_ready got=%b want=0", bus.msg_ready_o); end
        $display("txn async_reset en=%b dig=%h", obs_en, obs_dig);
        #1;
        rst = 1'b0;
        bus.game_value_i    = 16'h0042;
        bus.game_blank_lz_i = 1'b1;
        tick();
        total++; if (bus.msg_ready_o !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", bus.msg_ready_o); end
        total++; if (bus.msg_active_o !== 1'b0) begin bad++; $display("FAIL post_rst_active got=%b want=0", bus.msg_active_o); end
        total++; if (obs_en !== 4'b0011) begin bad++; $display("FAIL post_rst_en got=%b want=0011", obs_en); end
        total++; if (obs_dig !== 16'h0042) begin bad++; $display("FAIL post_rst_dig got=%h want=0042", obs_dig); end
        tick();
        total++; if (bus.msg_active_o !== 1'b0) begin bad++; $display("FAIL post_rst_active2 got=%b want=0", bus.msg_active_o); end
        $display("txn post_reset en=%b dig=%h ready=%b", obs_en, obs_dig, bus.msg_ready_o);
    endtask

    initial begin
        test_reset();
        test_blanking();
        test_blink();
        test_message();
        test_back_to_back();
        test_reset_mid_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
